// File: rtl/divider_m_n_bits_if.sv
// Handshake and data bundle between the MAC control logic (master) and the divider (slave).
// Define DIV_ZERO_CHECK_EN to add the div_by_zero flag.
interface divider_m_n_bits_if #(
  parameter int M = 4,
  parameter int N = 3
);
  logic         start;
  logic [M-1:0] num1;
  logic [N-1:0] num2;
  logic         busy;
  logic         done;
  logic [M-1:0] quotient;
  logic [N-1:0] remainder;
`ifdef DIV_ZERO_CHECK_EN
  logic         div_by_zero;

  modport master (output start, num1, num2,
                  input  busy, done, quotient, remainder, div_by_zero);
  modport slave  (input  start, num1, num2,
                  output busy, done, quotient, remainder, div_by_zero);
`else
  modport master (output start, num1, num2,
                  input  busy, done, quotient, remainder);
  modport slave  (input  start, num1, num2,
                  output busy, done, quotient, remainder);
`endif
endinterface

// File: rtl/divider_m_n_bits.sv
// Sequential restoring divider, M-bit dividend / N-bit divisor, one quotient bit per clock.
// Optional DIV_ZERO_CHECK_EN: zero divisor short-circuits to DONE and raises div_by_zero.
module divider_m_n_bits #(
  parameter int M = 4,
  parameter int N = 3
) (
  input logic              clk,
  input logic              rst,
  divider_m_n_bits_if.slave bus
);
  localparam int CW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q;
  logic [M-1:0]  dvd_q;
  logic [N-1:0]  dvs_q;
  logic [N-1:0]  rem_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q;
  logic [M-1:0]  quo_q;
  logic [N-1:0]  rmd_q;
  logic [N:0]    shift_d, rem_d;
  logic          qbit_d;

  // Partial remainder is always < divisor after a step, so N bits hold it;
  // only the shifted trial value needs the extra bit.
  always_comb begin
    shift_d = {rem_q, dvd_q[M-1]};
    qbit_d  = shift_d >= {1'b0, dvs_q};
    rem_d   = qbit_d ? shift_d - {1'b0, dvs_q} : shift_d;
  end

`ifdef DIV_ZERO_CHECK_EN
  logic dbz_q;
  assign bus.div_by_zero = dbz_q;
`endif

  // Quotient bits shift into the freed LSBs of the dividend register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
`ifdef DIV_ZERO_CHECK_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            dvd_q <= bus.num1;
            dvs_q <= bus.num2;
            rem_q <= '0;
            cnt_q <= '0;
`ifdef DIV_ZERO_CHECK_EN
            if (bus.num2 == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              quo_q   <= '1;
              rmd_q   <= bus.num1[N-1:0];
              dbz_q   <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              dbz_q   <= 1'b0;
            end
`else
            state_q <= RUN;
            busy_q  <= 1'b1;
`endif
          end
        end
        RUN: begin
          rem_q <= rem_d[N-1:0];
          dvd_q <= {dvd_q[M-2:0], qbit_d};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(M-1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quo_q   <= {dvd_q[M-2:0], qbit_d};
            rmd_q   <= rem_d[N-1:0];
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quo_q;
  assign bus.remainder = rmd_q;
endmodule

// File: tb/tb_divider_m_n_bits.sv
// Randomized and directed bench for divider_m_n_bits (M=4, N=3) with an arithmetic reference model.
// Build with DIV_ZERO_CHECK_EN defined to exercise the zero-divisor short-circuit.
module tb_divider_m_n_bits;
  localparam int M = 4;
  localparam int N = 3;
`ifdef DIV_ZERO_CHECK_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vec = 0;
  int   miss = 0;

  divider_m_n_bits_if #(.M(M), .N(N)) bus ();
  divider_m_n_bits #(.M(M), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [M-1:0] ref_q(int a, int b);
    return (b == 0) ? {M{1'b1}} : M'(a / b);
  endfunction

  function automatic logic [N-1:0] ref_r(int a, int b);
    return (b == 0) ? N'(a) : N'(a % b);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One division from IDLE; checks latency, busy during the run, results and single done pulse.
  task automatic run_div(input int a, input int b, input logic [M-1:0] eq,
                         input logic [N-1:0] er, input string tag);
    int lat = 0;
    bit seen = 0;
    int elat = (DZ && b == 0) ? 1 : M + 1;
    bus.start = 1'b1;
    bus.num1  = M'(a);
    bus.num2  = N'(b);
    while (!seen && lat < 3 * M + 10) begin
      tick();
      lat++;
      if (lat == 1) begin
        bus.start = 1'b0;
        bus.num1  = M'($urandom);
        bus.num2  = N'($urandom);
      end
      if (bus.done === 1'b1) seen = 1;
      else begin
        vec++;
        if (bus.busy !== 1'b1) begin
          miss++;
          $display("FAIL %s busy_in_run: got %b want 1 (cycle %0d)", tag, bus.busy, lat);
        end
      end
    end
    vec++;
    if (!seen || lat != elat) begin
      miss++;
      $display("FAIL %s latency: got %0d (seen=%0d) want %0d", tag, lat, seen, elat);
    end
    vec++;
    if (bus.quotient !== eq || bus.remainder !== er) begin
      miss++;
      $display("FAIL %s %0d/%0d result: got q=%0d r=%0d want q=%0d r=%0d",
               tag, a, b, bus.quotient, bus.remainder, eq, er);
    end
    vec++;
    if (bus.busy !== 1'b0) begin
      miss++;
      $display("FAIL %s busy_at_done: got %b want 0", tag, bus.busy);
    end
`ifdef DIV_ZERO_CHECK_EN
    vec++;
    if (bus.div_by_zero !== (b == 0)) begin
      miss++;
      $display("FAIL %s div_by_zero: got %b want %b", tag, bus.div_by_zero, b == 0);
    end
`endif
    tick();
    vec++;
    if (bus.done !== 1'b0) begin
      miss++;
      $display("FAIL %s done_pulse_width: got %b want 0", tag, bus.done);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== '0 || bus.remainder !== '0) begin
      miss++;
      $display("FAIL %s outputs: got busy=%b done=%b q=%0d r=%0d want all 0",
               tag, bus.busy, bus.done, bus.quotient, bus.remainder);
    end
`ifdef DIV_ZERO_CHECK_EN
    vec++;
    if (bus.div_by_zero !== 1'b0) begin
      miss++;
      $display("FAIL %s div_by_zero: got %b want 0", tag, bus.div_by_zero);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.num1 = '0;
    bus.num2 = '0;
    tick();
    tick();
    rst = 1'b0;
    check_zero_outputs("reset");
    run_div(13, 3, 4'd4, 3'd1, "first_13_3");
  endtask

  task automatic test_directed();
    run_div(15, 7, 4'd2, 3'd1, "d15_7");
    run_div(0, 5, 4'd0, 3'd0, "d0_5");
    run_div(15, 1, 4'd15, 3'd0, "d15_1");
    run_div(6, 7, 4'd0, 3'd6, "d6_7");
  endtask

  task automatic test_div_zero();
    run_div(9, 0, 4'd15, 3'd1, "dz9_0");
    run_div(10, 3, 4'd3, 3'd1, "after_dz");
  endtask

  task automatic test_exhaustive();
    for (int a = 0; a < (1 << M); a++)
      for (int b = 0; b < (1 << N); b++)
        run_div(a, b, ref_q(a, b), ref_r(a, b), "exh");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int a = int'($urandom_range((1 << M) - 1, 0));
      int b = int'($urandom_range((1 << N) - 1, 0));
      run_div(a, b, ref_q(a, b), ref_r(a, b), "rand");
    end
  endtask

  task automatic test_busy_ignore();
    int pulses = 0;
    logic [M-1:0] q0 = '0;
    logic [N-1:0] r0 = '0;
    bus.start = 1'b1;
    bus.num1 = 4'd13;
    bus.num2 = 3'd3;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    bus.num1 = 4'd7;
    bus.num2 = 3'd2;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 2 * M + 6; c++) begin
      if (bus.done === 1'b1) begin
        if (pulses == 0) begin
          q0 = bus.quotient;
          r0 = bus.remainder;
        end
        pulses++;
      end
      tick();
    end
    vec++;
    if (pulses != 1) begin
      miss++;
      $display("FAIL busy_ignore pulses: got %0d want 1", pulses);
    end
    vec++;
    if (q0 !== 4'd4 || r0 !== 3'd1) begin
      miss++;
      $display("FAIL busy_ignore result: got q=%0d r=%0d want q=4 r=1", q0, r0);
    end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    bus.start = 1'b1;
    bus.num1 = 4'd14;
    bus.num2 = 3'd3;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero_outputs("abort");
    for (int c = 0; c < 2 * M + 4; c++) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    vec++;
    if (pulses != 0) begin
      miss++;
      $display("FAIL abort_no_done: got %0d pulses want 0", pulses);
    end
    check_zero_outputs("abort_idle");
    run_div(14, 3, 4'd4, 3'd2, "after_abort");
  endtask

  // start held high: a new operand pair is presented at each done and accepted two edges later.
  task automatic test_back_to_back();
    int pulses = 0;
    int last = -1;
    int cyc = 0;
    int a = int'($urandom_range((1 << M) - 1, 0));
    int b = int'($urandom_range((1 << N) - 1, 1));
    logic [M-1:0] hq = '0;
    logic [N-1:0] hr = '0;
    bus.start = 1'b1;
    bus.num1 = M'(a);
    bus.num2 = N'(b);
    while (pulses < 5 && cyc < 8 * (M + 2) + 10) begin
      tick();
      cyc++;
      if (bus.done === 1'b1) begin
        pulses++;
        vec++;
        if (bus.quotient !== ref_q(a, b) || bus.remainder !== ref_r(a, b)) begin
          miss++;
          $display("FAIL b2b %0d/%0d result: got q=%0d r=%0d want q=%0d r=%0d",
                   a, b, bus.quotient, bus.remainder, ref_q(a, b), ref_r(a, b));
        end
        if (last >= 0) begin
          vec++;
          if (cyc - last != M + 2) begin
            miss++;
            $display("FAIL b2b period: got %0d want %0d", cyc - last, M + 2);
          end
        end
        last = cyc;
        hq = bus.quotient;
        hr = bus.remainder;
        a = int'($urandom_range((1 << M) - 1, 0));
        b = int'($urandom_range((1 << N) - 1, 1));
        bus.num1 = M'(a);
        bus.num2 = N'(b);
        if (pulses == 5) bus.start = 1'b0;
      end else if (pulses > 0) begin
        vec++;
        if (bus.quotient !== hq || bus.remainder !== hr) begin
          miss++;
          $display("FAIL b2b hold: got q=%0d r=%0d want q=%0d r=%0d",
                   bus.quotient, bus.remainder, hq, hr);
        end
      end
    end
    bus.start = 1'b0;
    vec++;
    if (pulses != 5) begin
      miss++;
      $display("FAIL b2b pulses: got %0d want 5", pulses);
    end
    tick();
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_directed();
    test_div_zero();
    test_exhaustive();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
